// File: rtl/beamformer_sequencer.sv
// ---------------------------------------------------------------------------
// beamformer_sequencer
//
// Run controller for the BRAM delay-beamformer datapath. A single start pulse
// launches one complete run:
//   IDLE -> LOAD -> DRAIN -> UNLOAD -> FLUSH -> DONE -> IDLE
// LOAD sweeps the input signal RAM, DRAIN keeps the beamformer enabled while
// the pipeline empties, UNLOAD sweeps the summed-output RAM, and FLUSH waits
// for the last read to come out of the RAM before the done pulse.
//
// Every output comes directly from a flop.
//
// Ports
//   clk              in   1         system clock, rising edge
//   rst              in   1         synchronous active-high reset
//   start            in   1         run request, ignored while busy
//   usedataflag      in   1         datapath output-valid strobe
//   readin_address   out  ADDR_W    input signal RAM read address
//   readinen         out  1         input signal RAM read enable
//   startbeamformer  out  1         beamformer enable
//   sumout_address   out  ADDR_W    summed-output RAM read address
//   sumouten         out  1         summed-output RAM read enable
//   out_valid        out  1         sum RAM read data valid this cycle
//   out_index        out  ADDR_W    sample index of the valid data
//   busy             out  1         run in progress (all states except IDLE)
//   done             out  1         one-cycle end-of-run pulse
//   good_count       out  ADDR_W+1  usedataflag pulses this run (saturating)
//   overrun          out  1         sticky: more than N_SAMPLES pulses this run
// ---------------------------------------------------------------------------
module beamformer_sequencer #(
    parameter int ADDR_W       = 11,
    parameter int N_SAMPLES    = 2048,
    parameter int RD_LAT       = 1,
    parameter int DRAIN_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              usedataflag,
    output logic [ADDR_W-1:0] readin_address,
    output logic              readinen,
    output logic              startbeamformer,
    output logic [ADDR_W-1:0] sumout_address,
    output logic              sumouten,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_index,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   good_count,
    output logic              overrun
);

    localparam int GC_W  = ADDR_W + 1;
    localparam int CNT_W = $clog2(DRAIN_CYCLES + RD_LAT + 1);

    // Terminal compare against N_SAMPLES-1 keeps N_SAMPLES == 2**ADDR_W legal.
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(N_SAMPLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0]  FLUSH_LAST = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [GC_W-1:0]   GC_ONE     = GC_W'(1);
    localparam logic [GC_W-1:0]   GC_MAX     = {GC_W{1'b1}};
    localparam logic [GC_W-1:0]   GC_LIMIT   = GC_W'(N_SAMPLES);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_DRAIN  = 3'd2,
        S_UNLOAD = 3'd3,
        S_FLUSH  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t              state_q,          state_d;
    logic [ADDR_W-1:0]   readin_address_q, readin_address_d;
    logic                readinen_q,       readinen_d;
    logic [ADDR_W-1:0]   sumout_address_q, sumout_address_d;
    logic                sumouten_q,       sumouten_d;
    logic [CNT_W-1:0]    cnt_q,            cnt_d;
    logic [RD_LAT-1:0]   sb_pipe_q,        sb_pipe_d;
    logic [RD_LAT-1:0]   vld_pipe_q,       vld_pipe_d;
    logic [ADDR_W-1:0]   idx_pipe_q [RD_LAT];
    logic [ADDR_W-1:0]   idx_pipe_d [RD_LAT];
    logic                busy_q,           busy_d;
    logic                done_q,           done_d;
    logic [GC_W-1:0]     good_count_q,     good_count_d;
    logic                overrun_q,        overrun_d;

    // Next-state logic for the run sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (readin_address_q == LAST_ADDR) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = S_UNLOAD;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_UNLOAD: begin
                if (sumout_address_q == LAST_ADDR) begin
                    state_d = S_FLUSH;
                end else begin
                    state_d = S_UNLOAD;
                end
            end
            S_FLUSH: begin
                if (cnt_q == FLUSH_LAST) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_FLUSH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output flags and address counters, decoded from the next state so that
    // the registered outputs line up with the state they describe.
    always_comb begin
        readinen_d       = (state_d == S_LOAD);
        sumouten_d       = (state_d == S_UNLOAD);
        busy_d           = (state_d != S_IDLE);
        done_d           = (state_d == S_DONE);
        readin_address_d = readin_address_q;
        sumout_address_d = sumout_address_q;

        // Read address restarts at 0 on LOAD entry, holds through the rest of
        // the run and returns to 0 in IDLE.
        if (state_d == S_LOAD) begin
            if (state_q == S_LOAD) begin
                readin_address_d = readin_address_q + ADDR_ONE;
            end else begin
                readin_address_d = '0;
            end
        end else if (state_d == S_IDLE) begin
            readin_address_d = '0;
        end else begin
            readin_address_d = readin_address_q;
        end

        if (state_d == S_UNLOAD) begin
            if (state_q == S_UNLOAD) begin
                sumout_address_d = sumout_address_q + ADDR_ONE;
            end else begin
                sumout_address_d = '0;
            end
        end else if (state_d == S_IDLE) begin
            sumout_address_d = '0;
        end else begin
            sumout_address_d = sumout_address_q;
        end
    end

    // Shared cycle counter for DRAIN and FLUSH; cleared on every state change.
    always_comb begin
        cnt_d = '0;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q == S_DRAIN) || (state_q == S_FLUSH)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = '0;
        end
    end

    // Latency-matching shift registers. The beamformer enable is the
    // LOAD+DRAIN window delayed by the RAM latency, so its first cycle meets
    // word 0 and it stays high N_SAMPLES+DRAIN_CYCLES cycles. The valid/index
    // pipe shifts zero indices when idle so out_index reads 0 outside a sweep.
    always_comb begin
        sb_pipe_d     = '0;
        vld_pipe_d    = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            idx_pipe_d[i] = '0;
        end
        sb_pipe_d[0]  = (state_q == S_LOAD) || (state_q == S_DRAIN);
        vld_pipe_d[0] = sumouten_q;
        if (sumouten_q) begin
            idx_pipe_d[0] = sumout_address_q;
        end else begin
            idx_pipe_d[0] = '0;
        end
        for (int i = 1; i < RD_LAT; i++) begin
            sb_pipe_d[i]  = sb_pipe_q[i-1];
            vld_pipe_d[i] = vld_pipe_q[i-1];
            idx_pipe_d[i] = idx_pipe_q[i-1];
        end
    end

    // Run statistics: cleared by an accepted start, counted only while busy.
    always_comb begin
        good_count_d = good_count_q;
        overrun_d    = overrun_q;
        if ((state_q == S_IDLE) && start) begin
            good_count_d = '0;
            overrun_d    = 1'b0;
        end else if (busy_q && usedataflag) begin
            // An increment from N_SAMPLES or above would exceed the run size.
            if (good_count_q >= GC_LIMIT) begin
                overrun_d = 1'b1;
            end else begin
                overrun_d = overrun_q;
            end
            if (good_count_q != GC_MAX) begin
                good_count_d = good_count_q + GC_ONE;
            end else begin
                good_count_d = good_count_q;
            end
        end else begin
            good_count_d = good_count_q;
            overrun_d    = overrun_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            readin_address_q <= '0;
            readinen_q       <= 1'b0;
            sumout_address_q <= '0;
            sumouten_q       <= 1'b0;
            cnt_q            <= '0;
            sb_pipe_q        <= '0;
            vld_pipe_q       <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                idx_pipe_q[i] <= '0;
            end
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            good_count_q     <= '0;
            overrun_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            readin_address_q <= readin_address_d;
            readinen_q       <= readinen_d;
            sumout_address_q <= sumout_address_d;
            sumouten_q       <= sumouten_d;
            cnt_q            <= cnt_d;
            sb_pipe_q        <= sb_pipe_d;
            vld_pipe_q       <= vld_pipe_d;
            for (int i = 0; i < RD_LAT; i++) begin
                idx_pipe_q[i] <= idx_pipe_d[i];
            end
            busy_q           <= busy_d;
            done_q           <= done_d;
            good_count_q     <= good_count_d;
            overrun_q        <= overrun_d;
        end
    end

    assign readin_address  = readin_address_q;
    assign readinen        = readinen_q;
    assign startbeamformer = sb_pipe_q[RD_LAT-1];
    assign sumout_address  = sumout_address_q;
    assign sumouten        = sumouten_q;
    assign out_valid       = vld_pipe_q[RD_LAT-1];
    assign out_index       = idx_pipe_q[RD_LAT-1];
    assign busy            = busy_q;
    assign done            = done_q;
    assign good_count      = good_count_q;
    assign overrun         = overrun_q;

endmodule

// File: tb/tb_beamformer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_beamformer_sequencer
//
// Self-checking bench for beamformer_sequencer with N_SAMPLES=8, RD_LAT=1,
// DRAIN_CYCLES=4. The reference model tracks only the cycle offset within a
// run plus the good_count/overrun values; expected outputs are derived from
// the phase windows of a run using plain arithmetic on that offset.
// ---------------------------------------------------------------------------
module tb_beamformer_sequencer;

    localparam int ADDR_W = 4;
    localparam int N      = 8;
    localparam int R      = 1;
    localparam int D      = 4;
    localparam int L      = 2 * N + D + R + 1;   // busy cycles per run, DONE last
    localparam int GC_SAT = (1 << (ADDR_W + 1)) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              usedataflag;
    logic [ADDR_W-1:0] readin_address;
    logic              readinen;
    logic              startbeamformer;
    logic [ADDR_W-1:0] sumout_address;
    logic              sumouten;
    logic              out_valid;
    logic [ADDR_W-1:0] out_index;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   good_count;
    logic              overrun;
    logic [7:0]        ram_q;

    always #5 clk = ~clk;

    beamformer_sequencer #(
        .ADDR_W       (ADDR_W),
        .N_SAMPLES    (N),
        .RD_LAT       (R),
        .DRAIN_CYCLES (D)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .usedataflag     (usedataflag),
        .readin_address  (readin_address),
        .readinen        (readinen),
        .startbeamformer (startbeamformer),
        .sumout_address  (sumout_address),
        .sumouten        (sumouten),
        .out_valid       (out_valid),
        .out_index       (out_index),
        .busy            (busy),
        .done            (done),
        .good_count      (good_count),
        .overrun         (overrun)
    );

    // Summed-output RAM model: one-cycle read latency, word[a] = 3*a.
    always @(posedge clk) begin
        if (sumouten) ram_q <= 8'(sumout_address) * 8'd3;
    end

    int n_vec = 0;
    int n_bad = 0;
    int t     = -1;     // cycle offset within the current run, -1 when idle
    int m_gc  = 0;
    int m_ov  = 0;
    int cnt_rde, cnt_sb, cnt_se, cnt_ov, cnt_done;

    typedef struct {
        int n_flags;
        int exp_gc;
        int exp_ov;
    } gc_vec_t;

    task automatic cmp(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0d, time %0t)", nm, act, exp, t, $time);
        end
    endtask

    task automatic check();
        int unl0, vld0;
        unl0 = N + D;
        vld0 = N + D + R;
        cmp("busy", int'(busy), int'(t >= 0));
        cmp("done", int'(done), int'(t == L - 1));
        cmp("readinen", int'(readinen), int'(t >= 0 && t < N));
        if (t < 0)            cmp("readin_address", int'(readin_address), 0);
        else if (t < N)       cmp("readin_address", int'(readin_address), t);
        else if (t < N + D)   cmp("readin_address_hold", int'(readin_address), N - 1);
        cmp("startbeamformer", int'(startbeamformer), int'(t >= R && t < R + N + D));
        cmp("sumouten", int'(sumouten), int'(t >= unl0 && t < unl0 + N));
        if (t < 0)                          cmp("sumout_address", int'(sumout_address), 0);
        else if (t >= unl0 && t < unl0 + N) cmp("sumout_address", int'(sumout_address), t - unl0);
        cmp("out_valid", int'(out_valid), int'(t >= vld0 && t < vld0 + N));
        if (t >= vld0 && t < vld0 + N) begin
            cmp("out_index", int'(out_index), t - vld0);
            cmp("ram_data", int'(ram_q), 3 * (t - vld0));
        end else if (t < 0) begin
            cmp("out_index_idle", int'(out_index), 0);
        end
        cmp("good_count", int'(good_count), m_gc);
        cmp("overrun", int'(overrun), m_ov);
    endtask

    // One clock: drive inputs, advance the model across the edge, check.
    task automatic step(input logic st, input logic uf, input logic r);
        start       = st;
        usedataflag = uf;
        rst         = r;
        @(posedge clk);
        if (r) begin
            t    = -1;
            m_gc = 0;
            m_ov = 0;
        end else if (t < 0) begin
            if (st) begin
                t    = 0;
                m_gc = 0;
                m_ov = 0;
            end
        end else begin
            if (uf) begin
                if (m_gc >= N) m_ov = 1;
                if (m_gc < GC_SAT) m_gc = m_gc + 1;
            end
            t = (t + 1 == L) ? -1 : t + 1;
        end
        #1;
        check();
        cnt_rde  += int'(readinen);
        cnt_sb   += int'(startbeamformer);
        cnt_se   += int'(sumouten);
        cnt_ov   += int'(out_valid);
        cnt_done += int'(done);
    endtask

    task automatic clr_counts();
        cnt_rde = 0; cnt_sb = 0; cnt_se = 0; cnt_ov = 0; cnt_done = 0;
    endtask

    initial begin
        gc_vec_t tbl [5];
        tbl[0] = '{n_flags: 0,  exp_gc: 0,  exp_ov: 0};
        tbl[1] = '{n_flags: 8,  exp_gc: 8,  exp_ov: 0};
        tbl[2] = '{n_flags: 9,  exp_gc: 9,  exp_ov: 1};
        tbl[3] = '{n_flags: 3,  exp_gc: 3,  exp_ov: 0};
        tbl[4] = '{n_flags: 12, exp_gc: 12, exp_ov: 1};

        clr_counts();
        start = 1'b0; usedataflag = 1'b0; rst = 1'b1;
        repeat (3) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);

        // Single run: phase lengths.
        clr_counts();
        step(1'b1, 1'b0, 1'b0);
        repeat (L) step(1'b0, 1'b0, 1'b0);
        cmp("s1_readinen_cycles", cnt_rde, 8);
        cmp("s1_sb_cycles", cnt_sb, 12);
        cmp("s1_sumouten_cycles", cnt_se, 8);
        cmp("s1_out_valid_cycles", cnt_ov, 8);
        cmp("s1_done_pulses", cnt_done, 1);

        // Start held every cycle: exactly one run.
        clr_counts();
        repeat (L + 1) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        cmp("s3_done_pulses", cnt_done, 1);
        cmp("s3_sb_cycles", cnt_sb, 12);

        // Reset on the 3rd UNLOAD cycle, then a fresh full run.
        clr_counts();
        step(1'b1, 1'b0, 1'b0);
        repeat (N + D + 2) step(1'b0, 1'b0, 1'b0);
        cmp("s4_in_unload", int'(sumout_address), 2);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        cmp("s4_no_done", cnt_done, 0);
        clr_counts();
        step(1'b1, 1'b0, 1'b0);
        repeat (L) step(1'b0, 1'b0, 1'b0);
        cmp("s4_rerun_done", cnt_done, 1);
        cmp("s4_rerun_valid", cnt_ov, 8);

        // good_count / overrun table.
        for (int v = 0; v < 5; v++) begin
            step(1'b1, 1'b0, 1'b0);
            for (int k = 0; k < L; k++) step(1'b0, 1'(k < tbl[v].n_flags), 1'b0);
            cmp("tbl_good_count", int'(good_count), tbl[v].exp_gc);
            cmp("tbl_overrun", int'(overrun), tbl[v].exp_ov);
        end

        // Back-to-back: start the cycle after done.
        clr_counts();
        step(1'b1, 1'b0, 1'b0);
        repeat (L) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        cmp("s6_restart_addr", int'(readin_address), 0);
        repeat (L) step(1'b0, 1'b0, 1'b0);
        cmp("s6_done_pulses", cnt_done, 2);
        cmp("s6_readinen_cycles", cnt_rde, 16);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 199) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
